rob_multi_wb: RTL and testbench
===============================

# rob_multi_wb

Parametrised reorder buffer: in-order allocation, out-of-order completion from N writeback channels, single in-order commit per cycle. Sits between the decoder/dispatch stage (allocation), the RS/LSB execute ends and CDB (writeback), and the register file and LSB (commit). It owns branch-mispredict recovery and produces the pipeline flush and redirect PC.

## Interface
- `ROB_SIZE_BIT`, default `ROB_WIDTH_BIT` (4): log2 of the entry count. Depth is `2**ROB_SIZE_BIT`.
- `N_WB`, default 2: number of writeback channels.
- `clk_in` in 1: clock. One clock; all state on its rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: global enable; low freezes all state.
- `alloc_valid` in 1: allocate one entry this cycle.
- `alloc_ready` out 1: `!full`.
- `alloc_done` in 1: entry completes at allocation (value already known).
- `alloc_val` in 32: initial value.
- `alloc_rd` in 5: destination register.
- `alloc_type` in `ROB_TYPE`: 0 Rd, 1 Store, 2 Branch, 3 Nop.
- `alloc_pc` in 32: instruction PC.
- `alloc_pred` in 32: predicted next PC (branches only).
- `alloc_tag` out `ROB_SIZE_BIT`: tag the entry receives (current tail).
- `wb_valid` in `N_WB`: per-channel writeback strobe.
- `wb_tag` in `N_WB*ROB_SIZE_BIT`: channel i at bits `[i*ROB_SIZE_BIT +: ROB_SIZE_BIT]`.
- `wb_val` in `N_WB*32`: channel i at `[i*32 +: 32]`. For branches, the value is the actual next PC.
- `commit_valid` out 1: one-cycle commit pulse.
- `commit_type` out `ROB_TYPE`; `commit_rd` out 5; `commit_val` out 32; `commit_tag` out `ROB_SIZE_BIT`.
- `q1_tag`, `q2_tag` in `ROB_SIZE_BIT`: operand queries.
- `q1_ready`, `q2_ready` out 1.
- `q1_val`, `q2_val` out 32.
- `flush_out` out 1: one-cycle mispredict flush pulse.
- `redirect_pc` out 32: correct PC, valid while `flush_out` is high.
- `count` out `ROB_SIZE_BIT+1`: occupied entries.
- `full` out 1; `empty` out 1.

## Operation
- Each entry holds: `busy`, `ready`, `value`, `rd`, `type`, `pc`, `pred`. `head` and `tail` are pointers that wrap from `2**ROB_SIZE_BIT-1` to 0.
- **Allocate:** when `alloc_valid && !full && !flush_out`, write the entry at `tail` with `busy=1` and `ready=alloc_done`, then advance `tail`. `alloc_valid` while full is ignored; the source must hold.
- **Writeback:** for each channel with `wb_valid[i]` whose tag is `busy`, set `ready=1` and `value=wb_val[i]`.
  - Writeback to a non-busy tag is ignored.
  - If two channels hit the same tag in one cycle, the higher index wins.
  - Writeback and allocation to the same slot in one cycle: allocation wins.
- **Commit:** when `busy[head] && ready[head]`:
  - register the head fields onto `commit_*`, pulse `commit_valid`, clear `busy`/`ready`, advance `head`.
  - Every type commits, including Store and Nop. The register file uses the commit only when `commit_type==0`; the LSB acts on `commit_type==1`.
- **Mispredict:** a committing Branch with `value != pred` sets `flush_out=1` and `redirect_pc=value`. On the same edge, all entries are cleared, `head=tail=count=0`, and that edge's allocation and writebacks are discarded.
- **Pointers and flags:** `count <= count + alloc_fire - commit_fire`. `full = (count == 2**ROB_SIZE_BIT)`; `empty = (count == 0)`. A commit does not free a slot for an allocation in the same cycle.
- **Queries** are combinational: `qN_ready = ready[qN_tag]`, `qN_val = value[qN_tag]`.
- **`rdy_in` low:** no state changes; `commit_valid` and `flush_out` read 0.

## Timing
- **Reset values:** every entry clear; `head=tail=count=0`; `commit_valid=0`, `commit_*=0`; `flush_out=0`; `redirect_pc=0`; `empty=1`; `full=0`; `alloc_ready=1`.
- A reset mid-operation discards all entries in one cycle.
- **Latencies:**
  - Allocation to tag visible: `alloc_tag` is valid combinationally in the allocation cycle.
  - Writeback at edge t to the head entry gives commit at edge t+1; `commit_valid` is high in cycle t+1.
  - `alloc_done=1` at the head gives commit on the edge after allocation.
- At most one commit per cycle. `flush_out` is exactly one cycle wide, and the cycle carrying it accepts no allocation.
- **Wrap-around:** with depth 16, after 16 allocations and 16 commits, `tail` and `head` both return to 0 and the next `alloc_tag` is 0.

## Configuration
- `ROB_WB_BYPASS_EN` defined: each query also matches same-cycle writebacks. A hit on a busy tag returns `ready=1` and the value from the highest matching channel, taking precedence over stored state.
- `ROB_WB_BYPASS_EN` undefined: queries see stored state only, so a writeback becomes visible one cycle later.

## Structure
- `const.v` gains:
  - `ROB_WIDTH_BIT`, `ROB_TYPE`;
  - type encodings `ROB_T_RD`, `ROB_T_ST`, `ROB_T_BR`, `ROB_T_NOP`;
  - default `ROB_N_WB`.
- Sub-module `rob_wb_select`: combinational. Given a tag and the packed writeback buses, returns hit and value with the highest-index-wins rule. One instance per entry for writeback, one per query port for bypass.

## Test plan
- **Reset then fill:** reset, then 16 allocations of type Rd with `alloc_done=0`.
  - Required: `alloc_tag` takes 0..15; after the 16th, `full=1`, `alloc_ready=0`, `count=16`; a 17th `alloc_valid` is ignored.
- **Out-of-order writeback:** allocate tags 0, 1, 2; write back tag 2=0x33 (channel 0), then tag 0=0x11 (channel 1), then tag 1=0x22.
  - Required: commits occur in order 0, 1, 2 with values 0x11, 0x22, 0x33, each exactly one cycle after its gating writeback.
- **Mispredict:** allocate Branch with `pred=0x104`, then two Rd entries; write back the branch with 0x200.
  - Required: `flush_out=1` and `redirect_pc=0x200` for one cycle; the Rd entries never commit; `count=0`, `empty=1`.
- **Same-tag collision:** channels 0 and 1 both write tag 5 in one cycle, with 0xA and 0xB.
  - Required: the stored value is 0xB.
  - With `ROB_WB_BYPASS_EN`, a query for tag 5 in that cycle also returns `ready=1` with value 0xB.
- **Stall and wrap:**
  - Hold `rdy_in=0` for 3 cycles while the head is ready. Required: no commit and `commit_valid=0`; the commit occurs on the first edge after `rdy_in` returns high.
  - Cycle 40 instructions through the buffer. Required: pointer wrap produces correct tags and in-order commits.

Source files
------------

// File: rtl/rob_multi_wb_pkg.sv
// rob_multi_wb_pkg
// Shared constants and type encodings for the reorder buffer slice.
//   ROB_WIDTH_BIT : default log2 of the entry count
//   ROB_TYPE      : width of the entry type field
//   ROB_N_WB      : default number of writeback channels
//   rob_type_e    : ROB_T_RD / ROB_T_ST / ROB_T_BR / ROB_T_NOP
package rob_multi_wb_pkg;
  localparam int ROB_WIDTH_BIT = 4;
  localparam int ROB_TYPE      = 2;
  localparam int ROB_N_WB      = 2;

  typedef enum logic [ROB_TYPE-1:0] {
    ROB_T_RD  = 2'd0,
    ROB_T_ST  = 2'd1,
    ROB_T_BR  = 2'd2,
    ROB_T_NOP = 2'd3
  } rob_type_e;
endpackage

// File: rtl/rob_multi_wb_if.sv
// rob_multi_wb_if
// Bundles the allocation, writeback and commit buses of the reorder buffer.
//   alloc_* : dispatch -> ROB (alloc_ready / alloc_tag flow back)
//   wb_*    : execute ends / CDB -> ROB, N_WB packed channels
//   commit_*: ROB -> register file / LSB
// Modports: master (pipeline side), slave (the ROB itself).
interface rob_multi_wb_if import rob_multi_wb_pkg::*; #(
  parameter int ROB_SIZE_BIT = ROB_WIDTH_BIT,
  parameter int N_WB         = ROB_N_WB
);
  logic                         alloc_valid;
  logic                         alloc_ready;
  logic                         alloc_done;
  logic [31:0]                  alloc_val;
  logic [4:0]                   alloc_rd;
  logic [ROB_TYPE-1:0]          alloc_type;
  logic [31:0]                  alloc_pc;
  logic [31:0]                  alloc_pred;
  logic [ROB_SIZE_BIT-1:0]      alloc_tag;

  logic [N_WB-1:0]              wb_valid;
  logic [N_WB*ROB_SIZE_BIT-1:0] wb_tag;
  logic [N_WB*32-1:0]           wb_val;

  logic                         commit_valid;
  logic [ROB_TYPE-1:0]          commit_type;
  logic [4:0]                   commit_rd;
  logic [31:0]                  commit_val;
  logic [ROB_SIZE_BIT-1:0]      commit_tag;

  modport master (
    output alloc_valid, alloc_done, alloc_val, alloc_rd, alloc_type, alloc_pc, alloc_pred,
    input  alloc_ready, alloc_tag,
    output wb_valid, wb_tag, wb_val,
    input  commit_valid, commit_type, commit_rd, commit_val, commit_tag
  );

  modport slave (
    input  alloc_valid, alloc_done, alloc_val, alloc_rd, alloc_type, alloc_pc, alloc_pred,
    output alloc_ready, alloc_tag,
    input  wb_valid, wb_tag, wb_val,
    output commit_valid, commit_type, commit_rd, commit_val, commit_tag
  );
endinterface

// File: rtl/rob_wb_select.sv
// rob_wb_select
// Combinational match of one tag against all writeback channels.
//   tag      : tag to look for
//   wb_valid : per-channel strobe
//   wb_tag   : packed channel tags
//   wb_val   : packed channel values
//   hit      : some valid channel carries this tag
//   val      : value of the highest-index matching channel
module rob_wb_select import rob_multi_wb_pkg::*; #(
  parameter int ROB_SIZE_BIT = ROB_WIDTH_BIT,
  parameter int N_WB         = ROB_N_WB
) (
  input  logic [ROB_SIZE_BIT-1:0]      tag,
  input  logic [N_WB-1:0]              wb_valid,
  input  logic [N_WB*ROB_SIZE_BIT-1:0] wb_tag,
  input  logic [N_WB*32-1:0]           wb_val,
  output logic                         hit,
  output logic [31:0]                  val
);
  // Ascending scan: a later (higher) channel overrides an earlier match.
  always_comb begin
    hit = 1'b0;
    val = '0;
    for (int i = 0; i < N_WB; i++) begin
      if (wb_valid[i] && (wb_tag[i*ROB_SIZE_BIT +: ROB_SIZE_BIT] == tag)) begin
        hit = 1'b1;
        val = wb_val[i*32 +: 32];
      end
    end
  end
endmodule

// File: rtl/rob_multi_wb.sv
// rob_multi_wb
// Reorder buffer: in-order allocation, out-of-order completion from N_WB
// writeback channels, one in-order commit per cycle, mispredict recovery.
//   clk_in, rst_in (sync, active high), rdy_in (global enable)
//   bus           : alloc / writeback / commit buses (slave side)
//   q1_*, q2_*    : combinational operand queries
//   flush_out     : one-cycle flush pulse, redirect_pc valid with it
//   count/full/empty : occupancy
// Optional feature macro: ROB_WB_BYPASS_EN (queries also see same-cycle
// writebacks).
module rob_multi_wb import rob_multi_wb_pkg::*; #(
  parameter int ROB_SIZE_BIT = ROB_WIDTH_BIT,
  parameter int N_WB         = ROB_N_WB
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  rob_multi_wb_if.slave           bus,
  input  logic [ROB_SIZE_BIT-1:0] q1_tag,
  input  logic [ROB_SIZE_BIT-1:0] q2_tag,
  output logic                    q1_ready,
  output logic                    q2_ready,
  output logic [31:0]             q1_val,
  output logic [31:0]             q2_val,
  output logic                    flush_out,
  output logic [31:0]             redirect_pc,
  output logic [ROB_SIZE_BIT:0]   count,
  output logic                    full,
  output logic                    empty
);
  localparam int DEPTH = 2 ** ROB_SIZE_BIT;

  logic                    busy_reg  [DEPTH];
  logic                    ready_reg [DEPTH];
  logic [31:0]             value_reg [DEPTH];
  logic [4:0]              rd_reg    [DEPTH];
  logic [ROB_TYPE-1:0]     type_reg  [DEPTH];
  logic [31:0]             pc_reg    [DEPTH];
  logic [31:0]             pred_reg  [DEPTH];

  logic [ROB_SIZE_BIT-1:0] head_reg, tail_reg;
  logic [ROB_SIZE_BIT:0]   count_reg;
  logic                    commit_valid_reg;
  logic [ROB_TYPE-1:0]     commit_type_reg;
  logic [4:0]              commit_rd_reg;
  logic [31:0]             commit_val_reg;
  logic [ROB_SIZE_BIT-1:0] commit_tag_reg;
  logic                    flush_reg;
  logic [31:0]             redirect_reg;

  logic                    wb_hit     [DEPTH];
  logic [31:0]             wb_hit_val [DEPTH];

  logic head_done, mispredict, alloc_fire;
  logic pc_unused;

  // One writeback matcher per entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wb
      rob_wb_select #(.ROB_SIZE_BIT(ROB_SIZE_BIT), .N_WB(N_WB)) u_sel (
        .tag      (ROB_SIZE_BIT'(gi)),
        .wb_valid (bus.wb_valid),
        .wb_tag   (bus.wb_tag),
        .wb_val   (bus.wb_val),
        .hit      (wb_hit[gi]),
        .val      (wb_hit_val[gi])
      );
    end
  endgenerate

  assign full        = (count_reg == (ROB_SIZE_BIT+1)'(DEPTH));
  assign empty       = (count_reg == '0);
  assign count       = count_reg;
  assign flush_out   = flush_reg & rdy_in;
  assign redirect_pc = redirect_reg;

  assign head_done  = busy_reg[head_reg] && ready_reg[head_reg];
  assign mispredict = head_done && (type_reg[head_reg] == ROB_T_BR) &&
                      (value_reg[head_reg] != pred_reg[head_reg]);
  // full is the registered occupancy, so a same-cycle commit cannot make room.
  assign alloc_fire = bus.alloc_valid && !full && !flush_out;

  assign bus.alloc_ready  = !full;
  assign bus.alloc_tag    = tail_reg;
  assign bus.commit_valid = commit_valid_reg & rdy_in;
  assign bus.commit_type  = commit_type_reg;
  assign bus.commit_rd    = commit_rd_reg;
  assign bus.commit_val   = commit_val_reg;
  assign bus.commit_tag   = commit_tag_reg;

  // The PC is carried per entry for debug probing; nothing downstream reads it.
  assign pc_unused = ^pc_reg[head_reg];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_reg[i]  <= 1'b0;
        ready_reg[i] <= 1'b0;
        value_reg[i] <= '0;
        rd_reg[i]    <= '0;
        type_reg[i]  <= '0;
        pc_reg[i]    <= '0;
        pred_reg[i]  <= '0;
      end
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      commit_valid_reg <= 1'b0;
      commit_type_reg  <= '0;
      commit_rd_reg    <= '0;
      commit_val_reg   <= '0;
      commit_tag_reg   <= '0;
      flush_reg        <= 1'b0;
      redirect_reg     <= '0;
    end else if (!rdy_in) begin
      // Frozen; drop the pulses so they cannot re-appear when rdy_in returns.
      commit_valid_reg <= 1'b0;
      flush_reg        <= 1'b0;
    end else begin
      commit_valid_reg <= head_done;
      flush_reg        <= mispredict;
      if (head_done) begin
        commit_type_reg <= type_reg[head_reg];
        commit_rd_reg   <= rd_reg[head_reg];
        commit_val_reg  <= value_reg[head_reg];
        commit_tag_reg  <= head_reg;
      end
      if (mispredict) begin
        redirect_reg <= value_reg[head_reg];
        for (int i = 0; i < DEPTH; i++) begin
          busy_reg[i]  <= 1'b0;
          ready_reg[i] <= 1'b0;
        end
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wb_hit[i] && busy_reg[i]) begin
            ready_reg[i] <= 1'b1;
            value_reg[i] <= wb_hit_val[i];
          end
        end
        if (head_done) begin
          busy_reg[head_reg]  <= 1'b0;
          ready_reg[head_reg] <= 1'b0;
          head_reg            <= head_reg + ROB_SIZE_BIT'(1);
        end
        // Last assignment so allocation overrides a writeback to the same slot.
        if (alloc_fire) begin
          busy_reg[tail_reg]  <= 1'b1;
          ready_reg[tail_reg] <= bus.alloc_done;
          value_reg[tail_reg] <= bus.alloc_val;
          rd_reg[tail_reg]    <= bus.alloc_rd;
          type_reg[tail_reg]  <= bus.alloc_type;
          pc_reg[tail_reg]    <= bus.alloc_pc;
          pred_reg[tail_reg]  <= bus.alloc_pred;
          tail_reg            <= tail_reg + ROB_SIZE_BIT'(1);
        end
        count_reg <= count_reg + (ROB_SIZE_BIT+1)'(alloc_fire)
                               - (ROB_SIZE_BIT+1)'(head_done);
      end
    end
  end

`ifdef ROB_WB_BYPASS_EN
  logic        q1_hit, q2_hit;
  logic [31:0] q1_byp, q2_byp;

  rob_wb_select #(.ROB_SIZE_BIT(ROB_SIZE_BIT), .N_WB(N_WB)) u_q1_sel (
    .tag(q1_tag), .wb_valid(bus.wb_valid), .wb_tag(bus.wb_tag), .wb_val(bus.wb_val),
    .hit(q1_hit), .val(q1_byp)
  );
  rob_wb_select #(.ROB_SIZE_BIT(ROB_SIZE_BIT), .N_WB(N_WB)) u_q2_sel (
    .tag(q2_tag), .wb_valid(bus.wb_valid), .wb_tag(bus.wb_tag), .wb_val(bus.wb_val),
    .hit(q2_hit), .val(q2_byp)
  );

  // A same-cycle writeback only counts when the tag is live.
  assign q1_ready = (q1_hit && busy_reg[q1_tag]) ? 1'b1   : ready_reg[q1_tag];
  assign q1_val   = (q1_hit && busy_reg[q1_tag]) ? q1_byp : value_reg[q1_tag];
  assign q2_ready = (q2_hit && busy_reg[q2_tag]) ? 1'b1   : ready_reg[q2_tag];
  assign q2_val   = (q2_hit && busy_reg[q2_tag]) ? q2_byp : value_reg[q2_tag];
`else
  assign q1_ready = ready_reg[q1_tag];
  assign q1_val   = value_reg[q1_tag];
  assign q2_ready = ready_reg[q2_tag];
  assign q2_val   = value_reg[q2_tag];
`endif
endmodule

// File: tb/tb_rob_multi_wb.sv
module tb_rob_multi_wb;
  import rob_multi_wb_pkg::*;

  localparam int SB = 4;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rst_in, rdy_in;
  logic [SB-1:0] q1_tag, q2_tag;
  logic          q1_ready, q2_ready;
  logic [31:0]   q1_val, q2_val;
  logic          flush_out;
  logic [31:0]   redirect_pc;
  logic [SB:0]   count;
  logic          full, empty;

  int tests_run = 0;
  int failed    = 0;

  typedef struct packed {
    logic [SB-1:0] tag;
    logic [31:0]   val;
    logic [4:0]    rd;
    logic [1:0]    typ;
  } exp_t;
  exp_t exp_q[$];

  rob_multi_wb_if #(.ROB_SIZE_BIT(SB), .N_WB(NW)) bus ();

  rob_multi_wb #(.ROB_SIZE_BIT(SB), .N_WB(NW)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val), .flush_out(flush_out), .redirect_pc(redirect_pc),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Commit scoreboard: every commit must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.commit_valid === 1'b1) begin
      exp_t got, e;
      got = '{tag: bus.commit_tag, val: bus.commit_val, rd: bus.commit_rd, typ: bus.commit_type};
      tests_run++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_commit got tag=%0d val=%h exp=none", got.tag, got.val);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failed++;
          $display("FAIL commit got tag=%0d val=%h rd=%0d type=%0d exp tag=%0d val=%h rd=%0d type=%0d",
                   got.tag, got.val, got.rd, got.typ, e.tag, e.val, e.rd, e.typ);
        end else
          $display("[TB] commit tag=%0d val=%h rd=%0d type=%0d", got.tag, got.val, got.rd, got.typ);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alloc_valid = 1'b0; bus.alloc_done = 1'b0; bus.alloc_val = '0; bus.alloc_rd = '0;
    bus.alloc_type = '0; bus.alloc_pc = '0; bus.alloc_pred = '0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_val = '0;
    q1_tag = '0; q2_tag = '0;
  endtask

  task automatic set_alloc(input logic done, input logic [31:0] val, input logic [4:0] rd,
                           input logic [1:0] typ, input logic [31:0] pc, input logic [31:0] pred);
    bus.alloc_valid = 1'b1; bus.alloc_done = done; bus.alloc_val = val; bus.alloc_rd = rd;
    bus.alloc_type = typ; bus.alloc_pc = pc; bus.alloc_pred = pred;
  endtask

  task automatic set_wb(input int ch, input logic [SB-1:0] tag, input logic [31:0] val);
    bus.wb_valid[ch] = 1'b1;
    bus.wb_tag[ch*SB +: SB] = tag;
    bus.wb_val[ch*32 +: 32] = val;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rdy_in = 1'b1;
    do_reset();
    #1;
    tests_run++; if (bus.commit_valid !== 1'b0) begin failed++; $display("FAIL reset_commit_valid got=%b exp=0", bus.commit_valid); end
    tests_run++; if (flush_out !== 1'b0) begin failed++; $display("FAIL reset_flush got=%b exp=0", flush_out); end
    tests_run++; if (redirect_pc !== 32'h0) begin failed++; $display("FAIL reset_redirect got=%h exp=0", redirect_pc); end
    tests_run++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin failed++; $display("FAIL reset_flags got count=%0d empty=%b full=%b exp 0/1/0", count, empty, full); end
    tests_run++; if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 4'd0) begin failed++; $display("FAIL reset_alloc got ready=%b tag=%0d exp 1/0", bus.alloc_ready, bus.alloc_tag); end
    tests_run++; if (bus.commit_val !== 32'h0 || bus.commit_tag !== 4'd0 || bus.commit_rd !== 5'd0 || bus.commit_type !== 2'd0) begin failed++; $display("FAIL reset_commit_fields got val=%h tag=%0d exp 0", bus.commit_val, bus.commit_tag); end
    $display("[TB] reset checked");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      set_alloc(1'b0, 32'(i), 5'(i), ROB_T_RD, 32'h1000 + 32'(4*i), 32'h0);
      #1;
      tests_run++; if (bus.alloc_tag !== 4'(i)) begin failed++; $display("FAIL fill_tag got=%0d exp=%0d", bus.alloc_tag, i); end
      tick();
      $display("[TB] alloc tag=%0d count=%0d", i, count);
    end
    tests_run++; if (full !== 1'b1 || bus.alloc_ready !== 1'b0 || count !== 5'd16) begin failed++; $display("FAIL fill_full got full=%b ready=%b count=%0d exp 1/0/16", full, bus.alloc_ready, count); end
    tick();  // 17th request held with alloc_valid high
    tests_run++; if (count !== 5'd16 || bus.alloc_tag !== 4'd0) begin failed++; $display("FAIL fill_overflow got count=%0d tag=%0d exp 16/0", count, bus.alloc_tag); end
    clear_inputs();
    do_reset();
    tests_run++; if (count !== 5'd0 || empty !== 1'b1 || bus.commit_valid !== 1'b0) begin failed++; $display("FAIL midreset got count=%0d empty=%b cv=%b exp 0/1/0", count, empty, bus.commit_valid); end
  endtask

  task automatic test_ooo_wb();
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b0, 32'h0, 5'(i + 1), ROB_T_RD, 32'h2000 + 32'(4*i), 32'h0);
      tick();
    end
    clear_inputs();
    exp_q.push_back('{tag: 4'd0, val: 32'h11, rd: 5'd1, typ: 2'd0});
    exp_q.push_back('{tag: 4'd1, val: 32'h22, rd: 5'd2, typ: 2'd0});
    exp_q.push_back('{tag: 4'd2, val: 32'h33, rd: 5'd3, typ: 2'd0});
    set_wb(0, 4'd2, 32'h33);
    tick();
    bus.wb_valid = '0;
    q1_tag = 4'd2; q2_tag = 4'd1;
    #1;
    tests_run++; if (bus.commit_valid !== 1'b0) begin failed++; $display("FAIL ooo_early_commit got=%b exp=0", bus.commit_valid); end
    tests_run++; if (q1_ready !== 1'b1 || q1_val !== 32'h33) begin failed++; $display("FAIL ooo_query2 got ready=%b val=%h exp 1/33", q1_ready, q1_val); end
    tests_run++; if (q2_ready !== 1'b0) begin failed++; $display("FAIL ooo_query1 got ready=%b exp=0", q2_ready); end
    set_wb(1, 4'd0, 32'h11);
    tick();  // edge t: head becomes ready
    bus.wb_valid = '0;
    tests_run++; if (bus.commit_valid !== 1'b0) begin failed++; $display("FAIL ooo_wb_edge got=%b exp=0", bus.commit_valid); end
    tick();  // edge t+1: commit tag 0
    tests_run++; if (bus.commit_valid !== 1'b1) begin failed++; $display("FAIL ooo_commit0 got=%b exp=1", bus.commit_valid); end
    set_wb(0, 4'd1, 32'h22);
    tick();
    bus.wb_valid = '0;
    tests_run++; if (bus.commit_valid !== 1'b0) begin failed++; $display("FAIL ooo_gap got=%b exp=0", bus.commit_valid); end
    tick();
    tests_run++; if (bus.commit_valid !== 1'b1 || bus.commit_tag !== 4'd1) begin failed++; $display("FAIL ooo_commit1 got cv=%b tag=%0d exp 1/1", bus.commit_valid, bus.commit_tag); end
    tick();
    tests_run++; if (bus.commit_valid !== 1'b1 || bus.commit_tag !== 4'd2) begin failed++; $display("FAIL ooo_commit2 got cv=%b tag=%0d exp 1/2", bus.commit_valid, bus.commit_tag); end
    tick();
    tests_run++; if (bus.commit_valid !== 1'b0 || empty !== 1'b1) begin failed++; $display("FAIL ooo_drain got cv=%b empty=%b exp 0/1", bus.commit_valid, empty); end
  endtask

  task automatic test_mispredict();
    clear_inputs();
    do_reset();
    set_alloc(1'b0, 32'h0, 5'd0, ROB_T_BR, 32'h100, 32'h104); tick();
    set_alloc(1'b1, 32'h1, 5'd4, ROB_T_RD, 32'h104, 32'h0);   tick();
    set_alloc(1'b1, 32'h2, 5'd5, ROB_T_RD, 32'h108, 32'h0);   tick();
    bus.alloc_valid = 1'b0;
    exp_q.push_back('{tag: 4'd0, val: 32'h200, rd: 5'd0, typ: 2'd2});
    set_wb(0, 4'd0, 32'h200);
    tick();
    bus.wb_valid = '0;
    tests_run++; if (flush_out !== 1'b0 || bus.commit_valid !== 1'b0) begin failed++; $display("FAIL mp_early got flush=%b cv=%b exp 0/0", flush_out, bus.commit_valid); end
    set_alloc(1'b1, 32'h9, 5'd9, ROB_T_RD, 32'h300, 32'h0);  // must be discarded twice
    tick();
    tests_run++; if (flush_out !== 1'b1 || redirect_pc !== 32'h200) begin failed++; $display("FAIL mp_flush got flush=%b pc=%h exp 1/200", flush_out, redirect_pc); end
    tests_run++; if (count !== 5'd0 || empty !== 1'b1) begin failed++; $display("FAIL mp_clear got count=%0d empty=%b exp 0/1", count, empty); end
    tick();
    tests_run++; if (flush_out !== 1'b0 || count !== 5'd0) begin failed++; $display("FAIL mp_after got flush=%b count=%0d exp 0/0", flush_out, count); end
    clear_inputs();
    tick(); tick();
    tests_run++; if (bus.commit_valid !== 1'b0 || empty !== 1'b1) begin failed++; $display("FAIL mp_no_rd_commit got cv=%b empty=%b exp 0/1", bus.commit_valid, empty); end
    $display("[TB] mispredict redirect=%h", redirect_pc);
  endtask

  task automatic test_collision();
    clear_inputs();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(1'b0, 32'h0, 5'(i), ROB_T_RD, 32'h0, 32'h0);
      tick();
    end
    bus.alloc_valid = 1'b0;
    set_wb(0, 4'd5, 32'hA);
    set_wb(1, 4'd5, 32'hB);
    q1_tag = 4'd5;
    #1;
`ifdef ROB_WB_BYPASS_EN
    tests_run++; if (q1_ready !== 1'b1 || q1_val !== 32'hB) begin failed++; $display("FAIL col_bypass got ready=%b val=%h exp 1/b", q1_ready, q1_val); end
`else
    tests_run++; if (q1_ready !== 1'b0) begin failed++; $display("FAIL col_nobypass got ready=%b exp=0", q1_ready); end
`endif
    tick();
    bus.wb_valid = '0;
    #1;
    tests_run++; if (q1_ready !== 1'b1 || q1_val !== 32'hB) begin failed++; $display("FAIL col_stored got ready=%b val=%h exp 1/b", q1_ready, q1_val); end
    set_wb(1, 4'd9, 32'h99);
    tick();
    bus.wb_valid = '0;
    q2_tag = 4'd9;
    #1;
    tests_run++; if (q2_ready !== 1'b0) begin failed++; $display("FAIL col_nonbusy got ready=%b exp=0", q2_ready); end
    do_reset();
    #1;
    tests_run++; if (q1_ready !== 1'b0) begin failed++; $display("FAIL col_reset_entry got ready=%b exp=0", q1_ready); end
    $display("[TB] collision tag5 stored");
  endtask

  task automatic test_stall();
    clear_inputs();
    do_reset();
    exp_q.push_back('{tag: 4'd0, val: 32'h55, rd: 5'd7, typ: 2'd0});
    set_alloc(1'b1, 32'h55, 5'd7, ROB_T_RD, 32'h400, 32'h0);
    tick();
    bus.alloc_valid = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (bus.commit_valid !== 1'b0 || count !== 5'd1) begin failed++; $display("FAIL stall_hold%0d got cv=%b count=%0d exp 0/1", i, bus.commit_valid, count); end
    end
    rdy_in = 1'b1;
    tick();
    tests_run++; if (bus.commit_valid !== 1'b1 || count !== 5'd0) begin failed++; $display("FAIL stall_release got cv=%b count=%0d exp 1/0", bus.commit_valid, count); end
    tick();
  endtask

  task automatic test_back_to_back_wrap();
    clear_inputs();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] v;
      logic [1:0]  t;
      v = 32'(i) * 3 + 1;
      t = 2'(i % 4);
      set_alloc(1'b1, v, 5'(i % 32), t, 32'h5000 + 32'(4*i), v);  // branches predicted correctly
      #1;
      tests_run++; if (bus.alloc_tag !== 4'(i % 16)) begin failed++; $display("FAIL wrap_tag%0d got=%0d exp=%0d", i, bus.alloc_tag, i % 16); end
      exp_q.push_back('{tag: 4'(i % 16), val: v, rd: 5'(i % 32), typ: t});
      tick();
      if (i > 0) begin
        tests_run++; if (bus.commit_valid !== 1'b1 || bus.commit_tag !== 4'((i - 1) % 16)) begin failed++; $display("FAIL wrap_commit%0d got cv=%b tag=%0d exp 1/%0d", i, bus.commit_valid, bus.commit_tag, (i - 1) % 16); end
      end
    end
    clear_inputs();
    tick();
    tick();
    tests_run++; if (bus.commit_valid !== 1'b0 || empty !== 1'b1 || flush_out !== 1'b0) begin failed++; $display("FAIL wrap_drain got cv=%b empty=%b flush=%b exp 0/1/0", bus.commit_valid, empty, flush_out); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ooo_wb();
    test_mispredict();
    test_collision();
    test_stall();
    test_back_to_back_wrap();
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
